// File: rtl/muladd_pkg.sv
// Shared types and defaults for the shift-add multiply-accumulate unit.
package muladd_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} muladd_state_t;

  localparam int MULADD_W = 8;

endpackage

// File: rtl/muladd_if.sv
// Request/response bundle for muladd_seq; ovf exists only when MULADD_OVF_EN is defined.
interface muladd_if import muladd_pkg::*; #(
  parameter int W = MULADD_W
);
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [W-1:0]   c;
  logic           i_valid;
  logic           busy;
  logic [2*W-1:0] result;
  logic           o_valid;
`ifdef MULADD_OVF_EN
  logic           ovf;

  modport master (output a, b, c, i_valid, input busy, result, o_valid, ovf);
  modport slave  (input a, b, c, i_valid, output busy, result, o_valid, ovf);
`else
  modport master (output a, b, c, i_valid, input busy, result, o_valid);
  modport slave  (input a, b, c, i_valid, output busy, result, o_valid);
`endif
endinterface

// File: rtl/muladd_step.sv
// One shift-add iteration: conditionally add the shifted multiplicand, then shift both operands.
module muladd_step import muladd_pkg::*; #(
  parameter int W = MULADD_W
) (
  input  logic [2*W-1:0] acc,
  input  logic [2*W-1:0] a_sh,
  input  logic [W-1:0]   b_sh,
  output logic [2*W-1:0] acc_n,
  output logic [2*W-1:0] a_sh_n,
  output logic [W-1:0]   b_sh_n
);
  // Sum is bounded by (2^W-1)^2 + (2^W-1), so the 2W-bit add never wraps.
  assign acc_n  = b_sh[0] ? (acc + a_sh) : acc;
  assign a_sh_n = {a_sh[2*W-2:0], 1'b0};
  assign b_sh_n = {1'b0, b_sh[W-1:1]};
endmodule

// File: rtl/muladd_seq.sv
// Sequential unsigned result = a*b + c with a fixed W+2 cycle issue interval.
// Optional overflow flag (high half non-zero) enabled by MULADD_OVF_EN.
module muladd_seq import muladd_pkg::*; #(
  parameter int W = MULADD_W
) (
  input  logic     clk,
  input  logic     rst,
  muladd_if.slave  bus
);
  localparam int              CNT_W = $clog2(W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

  muladd_state_t  state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] a_sh_q, a_sh_d;
  logic [W-1:0]   b_sh_q, b_sh_d;
  logic [2*W-1:0] result_q, result_d;
  logic           o_valid_q, o_valid_d;
  logic           busy_q, busy_d;
  logic [2*W-1:0] acc_n, a_sh_n;
  logic [W-1:0]   b_sh_n;
`ifdef MULADD_OVF_EN
  logic           ovf_q, ovf_d;
`endif

  muladd_step #(.W(W)) u_step (
    .acc    (acc_q),
    .a_sh   (a_sh_q),
    .b_sh   (b_sh_q),
    .acc_n  (acc_n),
    .a_sh_n (a_sh_n),
    .b_sh_n (b_sh_n)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    result_d  = result_q;
    o_valid_d = 1'b0;
    busy_d    = busy_q;
`ifdef MULADD_OVF_EN
    ovf_d     = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          acc_d   = {{W{1'b0}}, bus.c};
          a_sh_d  = {{W{1'b0}}, bus.a};
          b_sh_d  = bus.b;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      // Always W iterations so latency does not depend on the operands.
      RUN: begin
        acc_d   = acc_n;
        a_sh_d  = a_sh_n;
        b_sh_d  = b_sh_n;
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST) state_d = DONE;
      end
      DONE: begin
        result_d  = acc_q;
        o_valid_d = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
`ifdef MULADD_OVF_EN
        ovf_d     = |acc_q[2*W-1:W];
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      result_q  <= '0;
      o_valid_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef MULADD_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      result_q  <= result_d;
      o_valid_q <= o_valid_d;
      busy_q    <= busy_d;
`ifdef MULADD_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  // Working registers are always reloaded from IDLE before use.
  always_ff @(posedge clk) begin
    acc_q  <= acc_d;
    a_sh_q <= a_sh_d;
    b_sh_q <= b_sh_d;
  end

  assign bus.busy    = busy_q;
  assign bus.result  = result_q;
  assign bus.o_valid = o_valid_q;
`ifdef MULADD_OVF_EN
  assign bus.ovf     = ovf_q;
`endif
endmodule

// File: tb/tb_muladd_seq.sv
// Directed bench for muladd_seq (W=8): latency, arithmetic corners, handshake, abort by reset.
module tb_muladd_seq;
  import muladd_pkg::*;
  localparam int W = MULADD_W;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  muladd_if #(.W(W)) bus ();
  muladd_seq #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue from an idle DUT and wait (bounded) for the o_valid pulse.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                        output logic [2*W-1:0] res, output int lat, output int bcnt);
    bus.a = a; bus.b = b; bus.c = c; bus.i_valid = 1'b1;
    step();
    bus.i_valid = 1'b0;
    lat = 1;
    bcnt = 0;
    while (bus.o_valid !== 1'b1 && lat < 40) begin
      if (bus.busy === 1'b1) bcnt++;
      step();
      lat++;
    end
    res = bus.result;
  endtask

  logic [2*W-1:0] res;
  int lat, bcnt, n, pulses;
  int dd, dv;

  initial begin
    rst = 1'b1;
    bus.a = '0; bus.b = '0; bus.c = '0; bus.i_valid = 1'b0;
    step(); step();
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_ovalid", 32'(bus.o_valid), 0);
    chk("reset_result", 32'(bus.result), 0);
`ifdef MULADD_OVF_EN
    chk("reset_ovf", 32'(bus.ovf), 0);
`endif
    rst = 1'b0;
    step();

    // basic operation and timing
    run_op(8'd13, 8'd19, 8'd5, res, lat, bcnt);
    chk("t1_result", 32'(res), 252);
    chk("t1_latency", 32'(lat), 10);
    chk("t1_busy_cycles", 32'(bcnt), 9);
    chk("t1_busy_low_at_ovalid", 32'(bus.busy), 0);
`ifdef MULADD_OVF_EN
    chk("t1_ovf", 32'(bus.ovf), 0);
`endif
    step();
    chk("t1_ovalid_one_cycle", 32'(bus.o_valid), 0);
    chk("t1_result_held", 32'(bus.result), 252);

    // maximum operands
    run_op(8'd255, 8'd255, 8'd255, res, lat, bcnt);
    chk("t2_result", 32'(res), 65280);
`ifdef MULADD_OVF_EN
    chk("t2_ovf", 32'(bus.ovf), 1);
    step();
    chk("t2_ovf_held", 32'(bus.ovf), 1);
`else
    step();
`endif

    // zero operands
    run_op(8'd0, 8'd77, 8'd9, res, lat, bcnt);
    chk("t3_a_zero", 32'(res), 9);
    step();
    run_op(8'd77, 8'd0, 8'd9, res, lat, bcnt);
    chk("t3_b_zero", 32'(res), 9);
    step();

    // divider round trip
    run_op(8'd7, 8'd9, 8'd4, res, lat, bcnt);
    chk("t4_roundtrip", 32'(res), 67);
    step();
    for (int i = 0; i < 4; i++) begin
      dd = int'($urandom_range(255, 0));
      dv = int'($urandom_range(255, 1));
      run_op(8'(dd / dv), 8'(dv), 8'(dd % dv), res, lat, bcnt);
      chk("t4_rand_roundtrip", 32'(res), 32'(dd));
      step();
    end

    // request while busy is dropped, request in o_valid cycle is taken
    bus.a = 8'd13; bus.b = 8'd19; bus.c = 8'd5; bus.i_valid = 1'b1;
    step();
    bus.i_valid = 1'b0;
    step(); step();
    bus.a = 8'd1; bus.b = 8'd1; bus.c = 8'd0; bus.i_valid = 1'b1;
    step();
    bus.i_valid = 1'b0;
    n = 0;
    while (bus.o_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("t5_wait_after_ignored", 32'(n), 6);
    chk("t5_result", 32'(bus.result), 252);
    run_op(8'd7, 8'd9, 8'd4, res, lat, bcnt);
    chk("t5_accept_in_ovalid_cycle", 32'(res), 67);
    chk("t5_accept_latency", 32'(lat), 10);
    step();

    // abort by reset mid-run
    bus.a = 8'd13; bus.b = 8'd19; bus.c = 8'd5; bus.i_valid = 1'b1;
    step();
    bus.i_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_busy_after_rst", 32'(bus.busy), 0);
    chk("t6_ovalid_after_rst", 32'(bus.o_valid), 0);
    chk("t6_result_after_rst", 32'(bus.result), 0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.o_valid === 1'b1) pulses++;
    end
    chk("t6_no_ovalid", 32'(pulses), 0);
    run_op(8'd200, 8'd3, 8'd1, res, lat, bcnt);
    chk("t6_after_abort_result", 32'(res), 601);
    chk("t6_after_abort_latency", 32'(lat), 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
